sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/arm_mem_pkg.sv | 24 ++
 rtl/sram_read_buffer.sv | 46 ++++
 rtl/sram_controller.sv | 144 ++++++++++++++
 tb/tb_sram_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// Shared memory-subsystem definitions: SRAM controller state encoding,
// default data-memory base address and byte-address to word-index mapping.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } sramStateT;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
  localparam int          WORD_IDX_W        = 17;
  localparam int          SRAM_ADDR_W       = WORD_IDX_W + 1;

  typedef logic [WORD_IDX_W-1:0] wordIdxT;

  // Offset wraps modulo 2^32; byte-lane bits [1:0] and bits above 18 drop out.
  function automatic wordIdxT wordIndex(input logic [31:0] address,
                                        input logic [31:0] baseAddr);
    return wordIdxT'((address - baseAddr) >> 2);
  endfunction

endpackage

// File: rtl/sram_read_buffer.sv
// One-entry read buffer for sram_controller; the module only exists when
// SRAM_READ_BUFFER_EN is defined.
`ifdef SRAM_READ_BUFFER_EN
module sram_read_buffer
  import arm_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  wordIdxT     reqIdx,
  output logic        hit,
  output logic [31:0] hitData,
  input  logic        updateEn,
  input  logic [31:0] updateData,
  input  logic        fillEn,
  input  wordIdxT     fillIdx,
  input  logic [31:0] fillData
);

  logic        valid;
  wordIdxT     tag;
  logic [31:0] data;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (fillEn) begin
      valid <= 1'b1;
    end
  end

  // NOTE: tag and data are only observed through valid, so they carry no
  // reset; clearing valid alone invalidates the entry.
  always_ff @(posedge clk) begin
    if (fillEn) begin
      tag  <= fillIdx;
      data <= fillData;
    end else if (updateEn && valid && (reqIdx == tag)) begin
      data <= updateData;
    end
  end

  assign hit     = valid && (reqIdx == tag);
  assign hitData = data;

endmodule
`endif

// File: rtl/sram_controller.sv
// 32-bit load/store to 16-bit external SRAM bridge: each access is split into
// LOW and HIGH half-word phases. SRAM_READ_BUFFER_EN adds a one-entry read buffer.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   readEn,
  input  logic                   writeEn,
  input  logic [31:0]            address,
  input  logic [31:0]            writeData,
  output logic [31:0]            readData,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sramAddr,
  output logic [15:0]            sramDqOut,
  input  logic [15:0]            sramDqIn,
  output logic                   sramDqOe,
  output logic                   sramWeN
);

  localparam int              CNT_W    = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  sramStateT        state, nextState;
  logic [CNT_W-1:0] cnt;
  logic             phaseLast;
  logic             request;
  logic             readHit;
  logic             isWrite;
  wordIdxT          reqIdx;
  wordIdxT          curIdx;
  logic [15:0]      writeHi;
  logic             bufHit;
  logic [31:0]      bufData;

  assign request   = readEn | writeEn;
  assign reqIdx    = wordIndex(address, BASE_ADDR);
  assign phaseLast = (cnt == CNT_LAST);
  // A simultaneous write request always wins, so a hit needs a pure read.
  assign readHit   = (state == IDLE) && readEn && !writeEn && bufHit;

`ifdef SRAM_READ_BUFFER_EN
  sram_read_buffer uReadBuffer (
    .clk        (clk),
    .rst        (rst),
    .reqIdx     (reqIdx),
    .hit        (bufHit),
    .hitData    (bufData),
    .updateEn   ((state == IDLE) && writeEn),
    .updateData (writeData),
    .fillEn     ((state == HIGH) && phaseLast && !isWrite),
    .fillIdx    (curIdx),
    .fillData   ({sramDqIn, readData[15:0]})
  );
`else
  assign bufHit  = 1'b0;
  assign bufData = readData;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= ((state == LOW || state == HIGH) && !phaseLast) ? cnt + 1'b1 : '0;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (readHit)      nextState = DONE;
        else if (request) nextState = LOW;
      end
      LOW:     if (phaseLast) nextState = HIGH;
      HIGH:    if (phaseLast) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    sramWeN  = 1'b1;
    sramDqOe = 1'b0;
    case (state)
      IDLE: ready = !request;
      LOW, HIGH: begin
        sramWeN  = !isWrite;
        sramDqOe = isWrite;
      end
      DONE:    ready = 1'b1;
      default: ;
    endcase
  end

  // External address and data are registered so they are stable for the
  // whole of each half-word phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      readData  <= '0;
      sramAddr  <= '0;
      sramDqOut <= '0;
      isWrite   <= 1'b0;
      curIdx    <= '0;
      writeHi   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (readHit) begin
            readData <= bufData;
          end else if (request) begin
            isWrite  <= writeEn;
            curIdx   <= reqIdx;
            writeHi  <= writeData[31:16];
            sramAddr <= {reqIdx, 1'b0};
            if (writeEn) sramDqOut <= writeData[15:0];
          end
        end
        LOW: begin
          if (phaseLast) begin
            sramAddr <= {curIdx, 1'b1};
            if (isWrite) sramDqOut <= writeHi;
            else         readData[15:0] <= sramDqIn;
          end
        end
        HIGH: begin
          if (phaseLast && !isWrite) readData[31:16] <= sramDqIn;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: directed vector table, reset and
// buffer corner sequences, then randomized traffic against a word-level model.
module tb_sram_controller;

  localparam int          W        = 1;
  localparam logic [31:0] BASE     = 32'd1024;
  localparam int          FULL_LAT = 2 * W + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        readEn, writeEn;
  logic [31:0] address, writeData, readData;
  logic        ready;
  logic [17:0] sramAddr;
  logic [15:0] sramDqOut, sramDqIn;
  logic        sramDqOe, sramWeN;

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .readEn    (readEn),
    .writeEn   (writeEn),
    .address   (address),
    .writeData (writeData),
    .readData  (readData),
    .ready     (ready),
    .sramAddr  (sramAddr),
    .sramDqOut (sramDqOut),
    .sramDqIn  (sramDqIn),
    .sramDqOe  (sramDqOe),
    .sramWeN   (sramWeN)
  );

  always #5 clk = ~clk;

  // External asynchronous-read SRAM, written on the clock while WE# is low.
  bit [15:0] sramMem [0:262143];
  assign sramDqIn = sramMem[sramAddr];
  always @(posedge clk) if (!sramWeN) sramMem[sramAddr] <= sramDqOut;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: 32-bit word store plus visible-register expectations.
  logic [31:0] refMem [int];
  logic [31:0] lastRead = '0;
  logic [17:0] lastAddr = '0;
`ifdef SRAM_READ_BUFFER_EN
  bit          bufValid = 1'b0;
  logic [16:0] bufIdx   = '0;
`endif

  logic [17:0] trAddr  [0:39];
  logic [15:0] trDq    [0:39];
  logic        trWeN   [0:39];
  logic        trOe    [0:39];
  logic        trReady [0:39];

  // Called just after a rising edge with the DUT idle; returns just after
  // the edge that leaves DONE.
  task automatic runAndCheck(input string tag, input bit rd, input bit wr,
                             input logic [31:0] addr, input logic [31:0] data,
                             input logic [16:0] idx, input logic [31:0] expRead,
                             output int lat);
    bit hit;
    int expLat;
    logic [17:0] expA;
    hit = 1'b0;
`ifdef SRAM_READ_BUFFER_EN
    hit = !wr && bufValid && (bufIdx == idx);
`endif
    expLat = hit ? 1 : FULL_LAT;
    readEn = rd; writeEn = wr; address = addr; writeData = data;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      trAddr[c] = sramAddr; trDq[c] = sramDqOut; trWeN[c] = sramWeN;
      trOe[c] = sramDqOe; trReady[c] = ready;
      if (c > 0 && ready) begin
        lat = c; readEn = 1'b0; writeEn = 1'b0;
      end
      @(posedge clk); #1;
      if (lat >= 0) break;
      // Requests while busy must be ignored.
      readEn = 1'($urandom); writeEn = 1'($urandom);
      address = $urandom; writeData = $urandom;
    end
    check($sformatf("%s latency", tag), lat, expLat);
    check($sformatf("%s ready c0", tag), {31'd0, trReady[0]}, 32'd0);
    if (hit) begin
      for (int c = 0; c <= 1; c++) begin
        check($sformatf("%s hit sramAddr c%0d", tag, c), {14'd0, trAddr[c]}, {14'd0, lastAddr});
        check($sformatf("%s hit weN c%0d", tag, c), {31'd0, trWeN[c]}, 32'd1);
      end
    end else begin
      for (int c = 1; c <= 2 * W + 2; c++) begin
        expA = {idx, (c > W + 1) ? 1'b1 : 1'b0};
        check($sformatf("%s sramAddr c%0d", tag, c), {14'd0, trAddr[c]}, {14'd0, expA});
        check($sformatf("%s weN c%0d", tag, c), {31'd0, trWeN[c]}, {31'd0, !wr});
        check($sformatf("%s oe c%0d", tag, c), {31'd0, trOe[c]}, {31'd0, wr});
        if (wr)
          check($sformatf("%s dqOut c%0d", tag, c), {16'd0, trDq[c]},
                {16'd0, (c > W + 1) ? data[31:16] : data[15:0]});
      end
      check($sformatf("%s weN done", tag), {31'd0, trWeN[expLat]}, 32'd1);
      check($sformatf("%s oe done", tag), {31'd0, trOe[expLat]}, 32'd0);
      lastAddr = {idx, 1'b1};
    end
    check($sformatf("%s readData", tag), readData, expRead);
    if (wr) begin
      refMem[int'(idx)] = data;
    end else begin
      lastRead = expRead;
`ifdef SRAM_READ_BUFFER_EN
      bufValid = 1'b1;
      bufIdx   = idx;
`endif
    end
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [16:0] idx;
    logic [31:0] expRead;
  } vecT;

  vecT         vecs [8];
  logic [16:0] pool [16];

  initial begin
    int          lat;
    int          op;
    logic [16:0] idx;
    logic [31:0] addr, data;

    rst = 1'b1; readEn = 1'b0; writeEn = 1'b0; address = '0; writeData = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset ready", {31'd0, ready}, 32'd1);
    check("reset weN", {31'd0, sramWeN}, 32'd1);
    check("reset oe", {31'd0, sramDqOe}, 32'd0);
    check("reset readData", readData, 32'd0);
    check("reset sramAddr", {14'd0, sramAddr}, 32'd0);
    check("reset dqOut", {16'd0, sramDqOut}, 32'd0);
    @(posedge clk); #1;

    vecs[0] = '{1'b0, 1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 17'h00000, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0400, 32'h1111_2222, 17'h00000, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_040B, 32'hCAFE_F00D, 17'h00002, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_040B, 32'h3333_4444, 17'h00002, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_03FC, 32'h0BAD_C0DE, 17'h1FFFF, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h5555_6666, 17'h1FFFF, 32'h0BAD_C0DE};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_0404, 32'h1234_5678, 17'h00001, 32'h0BAD_C0DE};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0404, 32'h7777_8888, 17'h00001, 32'h1234_5678};
    for (int i = 0; i < 8; i++)
      runAndCheck($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                  vecs[i].data, vecs[i].idx, vecs[i].expRead, lat);

    // Back-to-back reads of one word: the second may hit the buffer.
    runAndCheck("reread1", 1'b1, 1'b0, 32'h400, 32'h0, 17'h0, 32'hDEAD_BEEF, lat);
    runAndCheck("reread2", 1'b1, 1'b0, 32'h400, 32'h0, 17'h0, 32'hDEAD_BEEF, lat);
`ifdef SRAM_READ_BUFFER_EN
    check("reread2 buffered latency", lat, 32'd1);
`else
    check("reread2 unbuffered latency", lat, 32'd5);
`endif

    // Reset during cycle 2 of a write.
    readEn = 1'b0; writeEn = 1'b1; address = 32'h410; writeData = 32'h5555_6666;
    @(negedge clk); @(posedge clk); #1;
    writeEn = 1'b0;
    @(negedge clk);
    check("midrst weN c1", {31'd0, sramWeN}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst weN c2 before edge", {31'd0, sramWeN}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst weN", {31'd0, sramWeN}, 32'd1);
    check("midrst oe", {31'd0, sramDqOe}, 32'd0);
    check("midrst ready", {31'd0, ready}, 32'd1);
    check("midrst sramAddr", {14'd0, sramAddr}, 32'd0);
    check("midrst dqOut", {16'd0, sramDqOut}, 32'd0);
    check("midrst readData", readData, 32'd0);
    @(posedge clk); #1;
    lastRead = '0;
    lastAddr = '0;
`ifdef SRAM_READ_BUFFER_EN
    bufValid = 1'b0;
`endif
    runAndCheck("postrst read", 1'b1, 1'b0, 32'h400, 32'h0, 17'h0, 32'hDEAD_BEEF, lat);

    // Randomized traffic over a word pool that includes the wrap region.
    for (int i = 0; i < 12; i++) pool[i] = 17'(i);
    for (int i = 12; i < 16; i++) pool[i] = 17'h1FFFF - 17'(i - 12);
    for (int i = 0; i < 16; i++) begin
      addr = BASE + {13'($urandom), pool[i], 2'($urandom)};
      runAndCheck($sformatf("fill%0d", i), 1'b0, 1'b1, addr, $urandom, pool[i], lastRead, lat);
    end
    for (int i = 0; i < 150; i++) begin
      idx  = pool[$urandom_range(0, 15)];
      op   = $urandom_range(0, 2);
      addr = BASE + {13'($urandom), idx, 2'($urandom)};
      data = $urandom;
      runAndCheck($sformatf("rnd%0d", i), op != 1, op != 0, addr, data, idx,
                  (op == 0) ? refMem[int'(idx)] : lastRead, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
